// File: rtl/sdcard_dma_pkg.sv
// Shared types for the SD card DMA engine.
// Holds the FSM state encoding and the error code values.
package sdcard_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } dma_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ABORT   = 2'b10;
    localparam logic [1:0] ERR_ALIGN   = 2'b11;

endpackage

// File: rtl/sdcard_dma_burst_calc.sv
// Burst length: min(remaining, MAX_BURST, words left before BOUNDARY).
// Ports: addr_off (address mod BOUNDARY), remaining words, burst_len (9b).
module sdcard_dma_burst_calc
    import sdcard_dma_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int BOUNDARY  = 4096,
    parameter int OFF_W     = $clog2(BOUNDARY)
) (
    input  logic [OFF_W-1:0] addr_off,
    input  logic [LEN_W-1:0] remaining,
    output logic [8:0]       burst_len
);

    localparam int WBL = $clog2(DATA_W / 8);

    logic [31:0] room;
    logic [31:0] lim;

    always_comb begin
        room = (32'(BOUNDARY) - 32'(addr_off)) >> WBL;
        lim  = 32'(remaining);
        if (32'(MAX_BURST) < lim) lim = 32'(MAX_BURST);
        if (room < lim) lim = room;
        burst_len = 9'(lim);
    end

endmodule

// File: rtl/sdcard_dma_engine.sv
// Bidirectional DMA between card FIFOs and the memory burst port.
// Ports: cfg_* control, status outputs, mem_* burst port, rxf_*/txf_* FIFOs.
module sdcard_dma_engine
    import sdcard_dma_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int LEN_W          = 16,
    parameter int DATA_W         = 32,
    parameter int MAX_BURST      = 16,
    parameter int BOUNDARY       = 4096,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              PCLK_i,
    input  logic              PRESETn_i,
    input  logic              cfg_start_i,
    input  logic              cfg_dir_i,
    input  logic [ADDR_W-1:0] cfg_base_addr_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic              cfg_abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [1:0]        err_code_o,
    output logic [LEN_W-1:0]  words_done_o,
    output logic              mem_req_o,
    input  logic              mem_ack_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [8:0]        mem_len_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_wvalid_o,
    input  logic              mem_wready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rvalid_i,
    output logic              mem_rready_o,
    input  logic [DATA_W-1:0] rxf_data_i,
    input  logic              rxf_empty_i,
    output logic              rxf_read_o,
    output logic [DATA_W-1:0] txf_data_o,
    output logic              txf_write_o,
    input  logic              txf_full_i
);

    localparam int WB    = DATA_W / 8;
    localparam int WBL   = $clog2(WB);
    localparam int OFF_W = $clog2(BOUNDARY);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    dma_state_t        state, state_nx;
    logic [1:0]        err_q, err_nx;
    logic              dir_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q, words_q;
    logic [8:0]        blen_q, beat_cnt, calc_len;
    logic [TW-1:0]     to_cnt;

    logic start_acc, misalign, abort_act;
    logic wr_beat, rd_beat, beat, last_beat;
    logic to_inc, to_hit;
    logic [OFF_W-1:0] calc_off;
    logic [LEN_W-1:0] calc_rem;

    // In IDLE the calculator sees the config so the first burst length
    // is registered together with the start; afterwards it sees the
    // registered address/remaining.
    assign calc_off = (state == ST_IDLE) ? cfg_base_addr_i[OFF_W-1:0]
                                         : addr_q[OFF_W-1:0];
    assign calc_rem = (state == ST_IDLE) ? cfg_len_i : rem_q;

    sdcard_dma_burst_calc #(
        .LEN_W     (LEN_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .BOUNDARY  (BOUNDARY),
        .OFF_W     (OFF_W)
    ) u_calc (
        .addr_off  (calc_off),
        .remaining (calc_rem),
        .burst_len (calc_len)
    );

    assign start_acc = (state == ST_IDLE) && cfg_start_i;
    assign misalign  = cfg_base_addr_i[WBL-1:0] != '0;
    assign abort_act = cfg_abort_i && (state == ST_CMD ||
                       state == ST_DATA || state == ST_NEXT);

    // Handshake strobes are all masked in the abort cycle.
    assign mem_req_o    = (state == ST_CMD) && !cfg_abort_i;
    assign mem_wvalid_o = (state == ST_DATA) && !dir_q &&
                          !rxf_empty_i && !cfg_abort_i;
    assign mem_rready_o = (state == ST_DATA) && dir_q &&
                          !txf_full_i && !cfg_abort_i;
    assign wr_beat      = mem_wvalid_o && mem_wready_i;
    assign rd_beat      = mem_rready_o && mem_rvalid_i;
    assign beat         = wr_beat || rd_beat;
    assign last_beat    = beat && (beat_cnt + 9'd1 == blen_q);

    assign rxf_read_o  = wr_beat;
    assign txf_write_o = rd_beat;
    assign mem_wdata_o = mem_wvalid_o ? rxf_data_i : '0;
    assign txf_data_o  = rd_beat ? mem_rdata_i : '0;

    assign mem_addr_o   = addr_q;
    assign mem_len_o    = blen_q;
    assign mem_we_o     = we_q;
    assign busy_o       = state != ST_IDLE;
    assign done_o       = state == ST_DONE;
    assign error_o      = state == ST_ERR;
    assign err_code_o   = err_q;
    assign words_done_o = words_q;

    assign to_inc = (state == ST_CMD || state == ST_DATA) &&
                    !mem_ack_i && !beat;
    assign to_hit = to_inc && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nx = state;
        err_nx   = err_q;
        unique case (state)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    if (misalign) begin
                        state_nx = ST_ERR;
                        err_nx   = ERR_ALIGN;
                    end else begin
                        err_nx   = ERR_NONE;
                        state_nx = (cfg_len_i == '0) ? ST_DONE : ST_CMD;
                    end
                end
            end
            ST_CMD, ST_DATA, ST_NEXT: begin
                if (abort_act) begin
                    state_nx = ST_ERR;
                    err_nx   = ERR_ABORT;
                end else if (to_hit) begin
                    state_nx = ST_ERR;
                    err_nx   = ERR_TIMEOUT;
                end else if (state == ST_CMD) begin
                    if (mem_ack_i) state_nx = ST_DATA;
                end else if (state == ST_DATA) begin
                    if (last_beat)
                        state_nx = (rem_q == LEN_W'(1)) ? ST_DONE
                                                        : ST_NEXT;
                end else begin
                    state_nx = ST_CMD;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            ST_ERR:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state    <= ST_IDLE;
            err_q    <= ERR_NONE;
            dir_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
            words_q  <= '0;
            blen_q   <= '0;
            beat_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            state  <= state_nx;
            err_q  <= err_nx;
            to_cnt <= to_inc ? to_cnt + TW'(1) : '0;
            if (start_acc) begin
                dir_q    <= cfg_dir_i;
                we_q     <= !cfg_dir_i;
                addr_q   <= cfg_base_addr_i;
                rem_q    <= cfg_len_i;
                words_q  <= '0;
                blen_q   <= calc_len;
                beat_cnt <= '0;
            end else begin
                if (beat) begin
                    addr_q   <= addr_q + ADDR_W'(WB);
                    rem_q    <= rem_q - LEN_W'(1);
                    words_q  <= words_q + LEN_W'(1);
                    beat_cnt <= beat_cnt + 9'd1;
                end
                if (state == ST_NEXT) begin
                    blen_q   <= calc_len;
                    beat_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdcard_dma_engine.sv
// Scoreboard bench for sdcard_dma_engine: directed transfers, expected
// commands/beats/completions queued and checked by a negedge monitor.
module tb_sdcard_dma_engine;

    typedef struct {
        logic [31:0] addr;
        logic [8:0]  len;
        logic        we;
    } cmd_t;

    typedef struct {
        logic        err;
        logic [1:0]  code;
        logic [15:0] words;
    } evt_t;

    logic        PCLK_i = 1'b0;
    logic        PRESETn_i;
    logic        cfg_start_i, cfg_dir_i, cfg_abort_i;
    logic [31:0] cfg_base_addr_i;
    logic [15:0] cfg_len_i;
    logic        busy_o, done_o, error_o;
    logic [1:0]  err_code_o;
    logic [15:0] words_done_o;
    logic        mem_req_o, mem_ack_i, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [8:0]  mem_len_o;
    logic [31:0] mem_wdata_o, mem_rdata_i, rxf_data_i, txf_data_o;
    logic        mem_wvalid_o, mem_wready_i, mem_rvalid_i, mem_rready_o;
    logic        rxf_empty_i, rxf_read_o, txf_write_o, txf_full_i;

    logic ack_en, wready_en;
    int   rx_idx, rx_avail, rd_idx, rd_left, tx_cnt, cyc, t_start;
    int   n_checks, n_err;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_wd[$];
    logic [31:0] exp_td[$];
    evt_t        exp_evt[$];

    always #5 PCLK_i = ~PCLK_i;

    sdcard_dma_engine #(.TIMEOUT_CYCLES(100)) dut (
        .PCLK_i          (PCLK_i),
        .PRESETn_i       (PRESETn_i),
        .cfg_start_i     (cfg_start_i),
        .cfg_dir_i       (cfg_dir_i),
        .cfg_base_addr_i (cfg_base_addr_i),
        .cfg_len_i       (cfg_len_i),
        .cfg_abort_i     (cfg_abort_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o),
        .err_code_o      (err_code_o),
        .words_done_o    (words_done_o),
        .mem_req_o       (mem_req_o),
        .mem_ack_i       (mem_ack_i),
        .mem_addr_o      (mem_addr_o),
        .mem_len_o       (mem_len_o),
        .mem_we_o        (mem_we_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_wvalid_o    (mem_wvalid_o),
        .mem_wready_i    (mem_wready_i),
        .mem_rdata_i     (mem_rdata_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rready_o    (mem_rready_o),
        .rxf_data_i      (rxf_data_i),
        .rxf_empty_i     (rxf_empty_i),
        .rxf_read_o      (rxf_read_o),
        .txf_data_o      (txf_data_o),
        .txf_write_o     (txf_write_o),
        .txf_full_i      (txf_full_i)
    );

    // FIFO and memory slave models
    assign mem_ack_i    = ack_en & mem_req_o;
    assign mem_wready_i = wready_en;
    assign rxf_empty_i  = rx_idx >= rx_avail;
    assign rxf_data_i   = 32'hA000_0000 + 32'(rx_idx);
    assign mem_rvalid_i = rd_left != 0;
    assign mem_rdata_i  = 32'hB000_0000 + 32'(rd_idx);

    always @(posedge PCLK_i) begin
        cyc <= cyc + 1;
        if (rxf_read_o) rx_idx <= rx_idx + 1;
        if (txf_write_o) tx_cnt <= tx_cnt + 1;
        if (mem_rvalid_i && mem_rready_o) rd_idx <= rd_idx + 1;
        rd_left <= rd_left
                 + ((mem_req_o && mem_ack_i && !mem_we_o) ? int'(mem_len_o) : 0)
                 - ((mem_rvalid_i && mem_rready_o) ? 1 : 0);
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: unexpected output, nothing queued", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents something
    always @(negedge PCLK_i) begin
        if (PRESETn_i) begin
            if (mem_req_o && mem_ack_i) begin
                if (exp_cmd.size() == 0) unexpected("cmd");
                else begin
                    cmd_t c;
                    c = exp_cmd.pop_front();
                    check("cmd_addr", mem_addr_o, c.addr);
                    check("cmd_len", mem_len_o, c.len);
                    check("cmd_we", mem_we_o, c.we);
                    check("cmd_no_cross",
                          ((mem_addr_o & 32'hFFF) + 32'(mem_len_o) * 4)
                          <= 32'd4096, 1);
                end
            end
            if (rxf_read_o) begin
                if (exp_wd.size() == 0) unexpected("wbeat");
                else check("wdata", mem_wdata_o, exp_wd.pop_front());
            end
            if (txf_write_o) begin
                if (exp_td.size() == 0) unexpected("txbeat");
                else check("txdata", txf_data_o, exp_td.pop_front());
            end
            if (done_o || error_o) begin
                if (exp_evt.size() == 0) unexpected("evt");
                else begin
                    evt_t e;
                    e = exp_evt.pop_front();
                    check("evt_is_err", error_o, e.err);
                    check("evt_code", err_code_o, e.code);
                    check("evt_words", words_done_o, e.words);
                end
            end
        end
    end

    task automatic start_xfer(input logic dir, input logic [31:0] base,
                              input logic [15:0] len);
        @(negedge PCLK_i);
        cfg_dir_i       = dir;
        cfg_base_addr_i = base;
        cfg_len_i       = len;
        cfg_start_i     = 1'b1;
        @(negedge PCLK_i);
        t_start     = cyc;
        cfg_start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 500; i++) begin
            if (!busy_o) return;
            @(negedge PCLK_i);
        end
        n_checks++;
        n_err++;
        $display("FAIL %s: still busy after 500 cycles", name);
    endtask

    task automatic queues_empty(input string name);
        check({name, "_cmdq"}, exp_cmd.size(), 0);
        check({name, "_wdq"}, exp_wd.size(), 0);
        check({name, "_tdq"}, exp_td.size(), 0);
        check({name, "_evtq"}, exp_evt.size(), 0);
    endtask

    task automatic push_wd(input int first, input int n);
        for (int k = 0; k < n; k++)
            exp_wd.push_back(32'hA000_0000 + 32'(first + k));
    endtask

    initial begin
        int t_err;
        n_checks = 0; n_err = 0; cyc = 0;
        rx_idx = 0; rx_avail = 1000; rd_idx = 0; rd_left = 0; tx_cnt = 0;
        ack_en = 1'b1; wready_en = 1'b1; txf_full_i = 1'b0;
        cfg_start_i = 1'b0; cfg_dir_i = 1'b0; cfg_abort_i = 1'b0;
        cfg_base_addr_i = '0; cfg_len_i = '0;
        PRESETn_i = 1'b0;
        repeat (3) @(negedge PCLK_i);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_error", error_o, 0);
        check("rst_code", err_code_o, 0);
        check("rst_words", words_done_o, 0);
        check("rst_req", mem_req_o, 0);
        check("rst_rxread", rxf_read_o, 0);
        PRESETn_i = 1'b1;

        // 1: write split at MAX_BURST
        exp_cmd.push_back('{32'h1000, 9'd16, 1'b1});
        exp_cmd.push_back('{32'h1040, 9'd4, 1'b1});
        push_wd(0, 20);
        exp_evt.push_back('{1'b0, 2'b00, 16'd20});
        start_xfer(1'b0, 32'h1000, 16'd20);
        wait_idle("t1");
        check("t1_words", words_done_o, 20);
        check("t1_rxreads", rx_idx, 20);
        queues_empty("t1");

        // 2: write split at the 4 KiB boundary
        exp_cmd.push_back('{32'h0FF8, 9'd2, 1'b1});
        exp_cmd.push_back('{32'h1000, 9'd6, 1'b1});
        push_wd(20, 8);
        exp_evt.push_back('{1'b0, 2'b00, 16'd8});
        start_xfer(1'b0, 32'h0FF8, 16'd8);
        wait_idle("t2");
        queues_empty("t2");

        // 3: read with TX FIFO full for 3 cycles mid-burst
        exp_cmd.push_back('{32'h2000, 9'd4, 1'b0});
        for (int k = 0; k < 4; k++)
            exp_td.push_back(32'hB000_0000 + 32'(k));
        exp_evt.push_back('{1'b0, 2'b00, 16'd4});
        start_xfer(1'b1, 32'h2000, 16'd4);
        for (int i = 0; i < 100 && tx_cnt < 2; i++) @(negedge PCLK_i);
        check("t3_two_beats", tx_cnt, 2);
        txf_full_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_rready_low", mem_rready_o, 0);
            check("t3_no_push", txf_write_o, 0);
            @(negedge PCLK_i);
        end
        txf_full_i = 1'b0;
        wait_idle("t3");
        check("t3_pushes", tx_cnt, 4);
        queues_empty("t3");

        // 4: no command ack -> timeout after 100 cycles
        ack_en = 1'b0;
        exp_evt.push_back('{1'b1, 2'b01, 16'd0});
        start_xfer(1'b0, 32'h3000, 16'd4);
        check("t4_req_up", mem_req_o, 1);
        t_err = -1;
        for (int i = 0; i < 300; i++) begin
            if (error_o) begin
                t_err = cyc;
                break;
            end
            @(negedge PCLK_i);
        end
        check("t4_latency", t_err - t_start, 100);
        wait_idle("t4");
        check("t4_req_low", mem_req_o, 0);
        check("t4_code_held", err_code_o, 1);
        ack_en = 1'b1;
        queues_empty("t4");

        // 5: abort after 5 beats of a 16-beat write
        rx_avail = 33;
        exp_cmd.push_back('{32'h4000, 9'd16, 1'b1});
        push_wd(28, 5);
        exp_evt.push_back('{1'b1, 2'b10, 16'd5});
        start_xfer(1'b0, 32'h4000, 16'd16);
        for (int i = 0; i < 100 && rx_idx < 33; i++) @(negedge PCLK_i);
        check("t5_five_reads", rx_idx, 33);
        rx_avail = 1000;
        cfg_abort_i = 1'b1;
        #1;
        check("t5_abort_wvalid", mem_wvalid_o, 0);
        check("t5_abort_read", rxf_read_o, 0);
        @(negedge PCLK_i);
        cfg_abort_i = 1'b0;
        wait_idle("t5");
        check("t5_no_more_reads", rx_idx, 33);
        check("t5_words", words_done_o, 5);
        queues_empty("t5");

        // 6: zero length completes with no command
        exp_evt.push_back('{1'b0, 2'b00, 16'd0});
        start_xfer(1'b0, 32'h5000, 16'd0);
        wait_idle("t6");
        queues_empty("t6");

        // 7: misaligned base
        exp_evt.push_back('{1'b1, 2'b11, 16'd0});
        start_xfer(1'b0, 32'h1002, 16'd4);
        wait_idle("t7");
        check("t7_code_held", err_code_o, 3);
        check("t7_rxreads", rx_idx, 33);
        queues_empty("t7");

        repeat (2) @(negedge PCLK_i);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
